// File: rtl/prog_address_decoder.sv
// rtl/prog_address_decoder.sv - runtime-programmable registered 68k address decoder with DTACK watchdog
// Optional feature macro: DECODER_OVERLAP_ERR_EN (multi-hit decodes become unmapped + sticky Overlap_H)
module prog_address_decoder #(
    parameter int NUM_REGIONS    = 8,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           Clk,
    input  logic                           Reset_H,
    input  logic [ADDR_W-1:0]              Address,
    input  logic                           AS_L,
    input  logic                           Dtack_L,
    input  logic                           CfgWrite_H,
    input  logic [$clog2(NUM_REGIONS)-1:0] CfgIndex,
    input  logic [ADDR_W-1:0]              CfgBase,
    input  logic [ADDR_W-1:0]              CfgMask,
    input  logic                           CfgEnable_H,
    output logic [NUM_REGIONS-1:0]         Select_H,
    output logic                           Unmapped_H,
    output logic                           BusError_L,
    output logic                           Overlap_H
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ACKED  = 2'd2,
        BERR   = 2'd3
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cntNext;
    logic              latchDecode;

    logic [ADDR_W-1:0]      baseReg [NUM_REGIONS];
    logic [ADDR_W-1:0]      maskReg [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] enReg;

    logic [NUM_REGIONS-1:0] hitVec;
    logic [NUM_REGIONS-1:0] prioSel;
    logic [NUM_REGIONS-1:0] decSel;
    logic                   decUnm;

    // Boot map: the debugger relies on ROM (0) and IO (1) being present out of reset.
    function automatic logic [ADDR_W-1:0] resetBase(input int i);
        case (i)
            1:       return ADDR_W'(32'h0040_0000);
            2:       return ADDR_W'(32'h0800_0000);
            default: return '0;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] resetMask(input int i);
        case (i)
            0:       return ADDR_W'(32'hFFFF_8000);
            1:       return ADDR_W'(32'hFFFF_0000);
            2:       return ADDR_W'(32'hFC00_0000);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                baseReg[i] <= resetBase(i);
                maskReg[i] <= resetMask(i);
                enReg[i]   <= (i < 3);
            end
        end else if (CfgWrite_H && (32'(CfgIndex) < NUM_REGIONS)) begin
            baseReg[CfgIndex] <= CfgBase;
            maskReg[CfgIndex] <= CfgMask;
            enReg[CfgIndex]   <= CfgEnable_H;
        end
    end

    always_comb begin
        hitVec = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            hitVec[i] = enReg[i] && ((Address & maskReg[i]) == (baseReg[i] & maskReg[i]));
        end
    end

    // Isolate the lowest set bit: lowest index wins.
    assign prioSel = hitVec & (~hitVec + NUM_REGIONS'(1));

`ifdef DECODER_OVERLAP_ERR_EN
    logic multiHit;
    assign multiHit = (hitVec & (hitVec - NUM_REGIONS'(1))) != '0;
    assign decSel   = multiHit ? '0 : prioSel;
    assign decUnm   = (hitVec == '0) || multiHit;

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            Overlap_H <= 1'b0;
        end else if (latchDecode && multiHit) begin
            Overlap_H <= 1'b1;
        end
    end
`else
    assign decSel    = prioSel;
    assign decUnm    = (hitVec == '0);
    assign Overlap_H = 1'b0;
`endif

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        latchDecode = 1'b0;
        case (state)
            IDLE: begin
                if (!AS_L) begin
                    stateNext   = ACTIVE;
                    cntNext     = '0;
                    latchDecode = 1'b1;
                end
            end
            ACTIVE: begin
                if (AS_L) begin
                    stateNext = IDLE;
                end else if (!Dtack_L) begin
                    stateNext = ACKED;
                end else begin
                    // Leaving for BERR here keeps the counter from ever wrapping.
                    if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        stateNext = BERR;
                    end
                    cntNext = cnt + CNT_W'(1);
                end
            end
            ACKED, BERR: begin
                if (AS_L) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            state      <= IDLE;
            cnt        <= '0;
            Select_H   <= '0;
            Unmapped_H <= 1'b0;
            BusError_L <= 1'b1;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            BusError_L <= (stateNext != BERR);
            if (latchDecode) begin
                Select_H   <= decSel;
                Unmapped_H <= decUnm;
            end else if (stateNext == IDLE) begin
                Select_H   <= '0;
                Unmapped_H <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_address_decoder.sv
// tb/tb_prog_address_decoder.sv - directed table-driven bench for prog_address_decoder
module tb_prog_address_decoder;

    logic        Clk = 1'b0;
    logic        Reset_H;
    logic [31:0] Address;
    logic        AS_L;
    logic        Dtack_L;
    logic        CfgWrite_H;
    logic [2:0]  CfgIndex;
    logic [31:0] CfgBase;
    logic [31:0] CfgMask;
    logic        CfgEnable_H;
    logic [7:0]  Select_H;
    logic        Unmapped_H;
    logic        BusError_L;
    logic        Overlap_H;

    int tests = 0;
    int fails = 0;

    prog_address_decoder #(
        .NUM_REGIONS(8),
        .ADDR_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .Clk(Clk),
        .Reset_H(Reset_H),
        .Address(Address),
        .AS_L(AS_L),
        .Dtack_L(Dtack_L),
        .CfgWrite_H(CfgWrite_H),
        .CfgIndex(CfgIndex),
        .CfgBase(CfgBase),
        .CfgMask(CfgMask),
        .CfgEnable_H(CfgEnable_H),
        .Select_H(Select_H),
        .Unmapped_H(Unmapped_H),
        .BusError_L(BusError_L),
        .Overlap_H(Overlap_H)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  sel;
        logic        unm;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] idx, input logic [31:0] base, input logic [31:0] mask, input logic en);
        CfgIndex    = idx;
        CfgBase     = base;
        CfgMask     = mask;
        CfgEnable_H = en;
        CfgWrite_H  = 1'b1;
        tick();
        CfgWrite_H  = 1'b0;
    endtask

    task automatic access(input string name, input logic [31:0] addr, input logic [7:0] sel, input logic unm);
        Address = addr;
        AS_L    = 1'b0;
        tick();
        check({name, " sel"}, 32'(Select_H), 32'(sel));
        check({name, " unm"}, 32'(Unmapped_H), 32'(unm));
        Dtack_L = 1'b0;
        tick();
        check({name, " berr"}, 32'(BusError_L), 32'd1);
        AS_L    = 1'b1;
        Dtack_L = 1'b1;
        tick();
        check({name, " release"}, 32'(Select_H), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 8'h01, 1'b0};
        vecs[1] = '{32'h0000_7FFC, 8'h01, 1'b0};
        vecs[2] = '{32'h0000_8000, 8'h00, 1'b1};
        vecs[3] = '{32'h0040_1234, 8'h02, 1'b0};
        vecs[4] = '{32'h0041_0000, 8'h00, 1'b1};
        vecs[5] = '{32'h0800_0000, 8'h04, 1'b0};
        vecs[6] = '{32'h0BFF_FFFC, 8'h04, 1'b0};
        vecs[7] = '{32'h0C00_0000, 8'h00, 1'b1};
        vecs[8] = '{32'hF003_FFFC, 8'h08, 1'b0};
        vecs[9] = '{32'hF004_0000, 8'h00, 1'b1};

        Reset_H = 1'b1; AS_L = 1'b1; Dtack_L = 1'b1; Address = '0;
        CfgWrite_H = 1'b0; CfgIndex = '0; CfgBase = '0; CfgMask = '0; CfgEnable_H = 1'b0;
        tick();
        tick();
        Reset_H = 1'b0;
        check("reset sel", 32'(Select_H), 32'd0);
        check("reset unm", 32'(Unmapped_H), 32'd0);
        check("reset berr", 32'(BusError_L), 32'd1);
        check("reset ovl", 32'(Overlap_H), 32'd0);

        // DTACK at E3 ends a ROM access cleanly
        Address = 32'h0000_1000; AS_L = 1'b0;
        tick();
        check("rom sel E0", 32'(Select_H), 32'h01);
        tick(); tick();
        Dtack_L = 1'b0;
        tick();
        tick();
        check("rom no berr", 32'(BusError_L), 32'd1);
        AS_L = 1'b1; Dtack_L = 1'b1;
        tick();
        check("rom release", 32'(Select_H), 32'd0);

        cfg(3'd3, 32'hF000_0000, 32'hFFFC_0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            access($sformatf("vec%0d", i), vecs[i].addr, vecs[i].sel, vecs[i].unm);
        end

        // Unmapped access times out after E4 and holds until AS_L rises
        Address = 32'h2000_0000; AS_L = 1'b0;
        tick();
        check("to unm", 32'(Unmapped_H), 32'd1);
        tick(); tick(); tick();
        check("to berr E3", 32'(BusError_L), 32'd1);
        tick();
        check("to berr E4", 32'(BusError_L), 32'd0);
        tick(); tick();
        check("to berr held", 32'(BusError_L), 32'd0);
        AS_L = 1'b1;
        tick();
        check("to berr clear", 32'(BusError_L), 32'd1);
        check("to unm clear", 32'(Unmapped_H), 32'd0);

        // DTACK sampled exactly at E4 beats the watchdog
        Address = 32'h2000_0000; AS_L = 1'b0;
        tick();
        tick(); tick(); tick();
        Dtack_L = 1'b0;
        tick();
        check("dtack E4 berr", 32'(BusError_L), 32'd1);
        Dtack_L = 1'b1;
        tick(); tick();
        check("dtack E4 hold", 32'(BusError_L), 32'd1);
        AS_L = 1'b1;
        tick();

        // Region 4 duplicates region 1
        cfg(3'd4, 32'h0040_0000, 32'hFFFF_0000, 1'b1);
        Address = 32'h0040_0010; AS_L = 1'b0;
        tick();
`ifdef DECODER_OVERLAP_ERR_EN
        check("ovl sel", 32'(Select_H), 32'd0);
        check("ovl unm", 32'(Unmapped_H), 32'd1);
        check("ovl flag", 32'(Overlap_H), 32'd1);
        tick(); tick(); tick(); tick();
        check("ovl berr", 32'(BusError_L), 32'd0);
        AS_L = 1'b1;
        tick();
        check("ovl sticky", 32'(Overlap_H), 32'd1);
`else
        check("ovl sel", 32'(Select_H), 32'h02);
        check("ovl unm", 32'(Unmapped_H), 32'd0);
        check("ovl flag", 32'(Overlap_H), 32'd0);
        Dtack_L = 1'b0;
        tick();
        AS_L = 1'b1; Dtack_L = 1'b1;
        tick();
        check("ovl after", 32'(Overlap_H), 32'd0);
`endif
        cfg(3'd4, 32'h0, 32'h0, 1'b0);

        // Reprogramming the selected region mid-access leaves the latched select alone
        Address = 32'hF000_0000; AS_L = 1'b0;
        tick();
        check("inflight sel", 32'(Select_H), 32'h08);
        cfg(3'd3, 32'hE000_0000, 32'hFFFC_0000, 1'b1);
        check("inflight kept", 32'(Select_H), 32'h08);
        Dtack_L = 1'b0;
        tick();
        AS_L = 1'b1; Dtack_L = 1'b1;
        tick();
        access("moved old", 32'hF000_0000, 8'h00, 1'b1);
        access("moved new", 32'hE000_0000, 8'h08, 1'b0);

        // Reset in the middle of an ACTIVE access
        Address = 32'hE000_0000; AS_L = 1'b0;
        tick();
        tick();
        Reset_H = 1'b1;
        tick();
        Reset_H = 1'b0;
        check("midrst sel", 32'(Select_H), 32'd0);
        check("midrst unm", 32'(Unmapped_H), 32'd0);
        check("midrst berr", 32'(BusError_L), 32'd1);
        check("midrst ovl", 32'(Overlap_H), 32'd0);
        AS_L = 1'b1;
        tick();
        access("post rst r3", 32'hE000_0000, 8'h00, 1'b1);
        access("post rst r1", 32'h0040_0000, 8'h02, 1'b0);
        access("post rst f0", 32'hF003_FFFC, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prog_address_decoder.md
# prog_address_decoder

Runtime-programmable, registered address decoder for the 68k system bus, replacing fixed-map decoding. It holds NUM_REGIONS base/mask windows loaded through a configuration port, latches one-hot chip selects per bus cycle (qualified by AS_L), and runs a DTACK watchdog that raises BusError_L for unmapped or unanswered accesses. It sits between the CPU address/strobe lines and the ROM, RAM, DRAM, IO and peripheral select inputs.

## Interface
- NUM_REGIONS, 8: number of decode windows (2..16).
- ADDR_W, 32: address width.
- TIMEOUT_CYCLES, 255: Clk cycles without DTACK before bus error (1..65535).
- Clk  in  1  system clock; all state changes on rising edge.
- Reset_H  in  1  synchronous, active-high reset.
- Address  in  ADDR_W  CPU address.
- AS_L  in  1  address strobe, active low.
- Dtack_L  in  1  OR-ed slave acknowledge, active low.
- CfgWrite_H  in  1  write CfgBase/CfgMask/CfgEnable_H into region CfgIndex.
- CfgIndex  in  clog2(NUM_REGIONS)  target region.
- CfgBase  in  ADDR_W  window base.
- CfgMask  in  ADDR_W  compare mask (1 = bit compared).
- CfgEnable_H  in  1  region enable.
- Select_H  out  NUM_REGIONS  registered one-hot chip selects.
- Unmapped_H  out  1  current access hit no region.
- BusError_L  out  1  bus error to CPU, active low.
- Overlap_H  out  1  sticky multi-hit flag (see Configuration).

## Operation
- Hit i = Enable[i] && ((Address & Mask[i]) == (Base[i] & Mask[i])).
- Priority: lowest hitting index wins; Select_H one-hot or zero.
- Reset region table: region 0 base 0x0000_0000 mask 0xFFFF_8000 enabled (32 KB ROM); region 1 base 0x0040_0000 mask 0xFFFF_0000 enabled (IO); region 2 base 0x0800_0000 mask 0xFC00_0000 enabled (64 MB DRAM); all others base 0, mask 0, disabled. Debugger depends on regions 0 and 1.
- FSM states: IDLE, ACTIVE, ACKED, BERR.
  - IDLE: AS_L sampled low -> ACTIVE; latch Select_H and Unmapped_H from current Address; clear counter.
  - ACTIVE: Dtack_L low -> ACKED; else counter increments; counter reaching TIMEOUT_CYCLES -> BERR.
  - ACKED: counter frozen; waits.
  - BERR: BusError_L low.
  - Any non-IDLE state with AS_L sampled high -> IDLE; Select_H, Unmapped_H cleared, BusError_L high.
- Unmapped access follows same path: no select, watchdog produces bus error.
- Config write takes effect at the edge it is sampled; latched selects of an in-flight access are unaffected. CfgIndex >= NUM_REGIONS: write ignored.
- Reset mid-access: all state to reset values at that edge, FSM to IDLE, table to reset map.
- Counter width clog2(TIMEOUT_CYCLES+1); never wraps (saturates via BERR transition).

## Timing
- Reset values: Select_H = 0, Unmapped_H = 0, BusError_L = 1, Overlap_H = 0, FSM IDLE.
- Edge E0 samples AS_L low: Select_H/Unmapped_H valid after E0 (1-cycle latency).
- Edges E1..ET in ACTIVE with Dtack_L high: BusError_L low after ET, T = TIMEOUT_CYCLES.
- Dtack_L low sampled at ET: ACKED wins, no bus error.
- AS_L sampled high at edge Ex: outputs inactive after Ex. AS_L high and Dtack_L low at same edge: IDLE.
- Address changes while AS_L low are ignored until next IDLE->ACTIVE.

## Configuration
- DECODER_OVERLAP_ERR_EN defined: a decode with two or more hits latches no select, sets Unmapped_H, and sets Overlap_H sticky until Reset_H; access ends in bus error via watchdog.
- Not defined: lowest-index priority applies; Overlap_H tied 0.

## Test plan
- Reset, AS_L low at 0x0000_1000 -> Select_H = 0x01 after E0; Dtack_L low at E3 -> no bus error; AS_L high -> Select_H = 0 next cycle.
- Write region 3 base 0xF000_0000 mask 0xFFFC_0000 enabled; access 0xF003_FFFC -> Select_H = 0x08; 0xF004_0000 -> Unmapped_H = 1.
- Unmapped 0x2000_0000, TIMEOUT_CYCLES = 4, no DTACK -> BusError_L low after E4, held until AS_L high.
- DTACK at exactly E4 with TIMEOUT_CYCLES = 4 -> BusError_L stays 1.
- Region 4 duplicates region 1 window: macro off -> Select_H = 0x02; macro on -> Select_H = 0, Overlap_H = 1 sticky, bus error after timeout.
- Reset_H pulsed mid-ACTIVE after region 3 reconfigured -> outputs inactive next cycle, region 3 disabled, 0x0040_0000 selects region 1.
